mem_port: RTL and testbench

Single-port memory responder serving the multicycle core's controller-side memory interface (instruction fetch, load, store). It accepts one request at a time from the core datapath and drives a synchronous block RAM with byte-lane write enables. It returns sign- or zero-extended load data and a one-cycle completion pulse, so the controller FSM holds its FETCH/MEMREAD/MEMWRITE states until that pulse.

---
 rtl/mem_port.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// ============================================================================
// Module      : mem_port
// Description : Single-request memory responder between the multicycle core
//               controller and a synchronous byte-lane BRAM. Optional
//               misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port #(
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lane;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_bram_en;
  logic [3:0]        r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [31:0]       r_bram_wdata;

  logic              w_accept;
  logic              w_mis;
  logic              w_skip;
  logic [3:0]        w_st_we;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_ld_data;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;

  // Byte-address bits above the BRAM word range alias onto the same words.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, addr[31:ADDR_W+2]};

  assign w_accept = (r_state == S_IDLE) && req;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_mis;

  always_comb begin
    w_mis = 1'b0;
    case (funct3[1:0])
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = addr[0];
      default: w_mis = (addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mis <= 1'b0;
    end else if (w_accept) begin
      r_mis <= w_mis;
    end
  end

  assign w_skip = r_mis;
  assign err    = (r_state == S_DONE) && r_mis;
`else
  assign w_mis  = 1'b0;
  assign w_skip = 1'b0;
  assign err    = 1'b0;
`endif

  // Store lane steering from the live request inputs, captured on accept.
  always_comb begin
    w_st_we    = 4'b1111;
    w_st_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_st_we    = 4'b0001 << addr[1:0];
        w_st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_st_we    = addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_st_we    = 4'b1111;
        w_st_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    w_ld_byte = bram_rdata[7:0];
    case (r_lane)
      2'd0: w_ld_byte = bram_rdata[7:0];
      2'd1: w_ld_byte = bram_rdata[15:8];
      2'd2: w_ld_byte = bram_rdata[23:16];
      2'd3: w_ld_byte = bram_rdata[31:24];
      default: w_ld_byte = bram_rdata[7:0];
    endcase
    w_ld_half = r_lane[1] ? bram_rdata[31:16] : bram_rdata[15:0];
    case (r_funct3[1:0])
      2'b00:   w_ld_data = {{24{~r_funct3[2] & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = {{16{~r_funct3[2] & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = bram_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = (r_we || w_skip) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_cnt        <= '0;
      r_rdata      <= 32'h0;
      r_bram_en    <= 1'b0;
      r_bram_we    <= 4'b0000;
      r_bram_addr  <= '0;
      r_bram_wdata <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_bram_en <= 1'b0;
      r_bram_we <= 4'b0000;

      if (w_accept) begin
        r_we         <= we;
        r_funct3     <= funct3;
        r_lane       <= addr[1:0];
        r_bram_addr  <= addr[ADDR_W+1:2];
        r_bram_wdata <= w_st_wdata;
        if (!w_mis) begin
          r_bram_en <= 1'b1;
          r_bram_we <= we ? w_st_we : 4'b0000;
        end
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= C_CNT_LOAD;
        if (w_skip) begin
          r_rdata <= 32'h0;
        end
      end

      if (r_state == S_WAIT) begin
        if (r_cnt == '0) begin
          r_rdata <= w_ld_data;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign done       = (r_state == S_DONE);
  assign rdata      = r_rdata;
  assign bram_en    = r_bram_en;
  assign bram_we    = r_bram_we;
  assign bram_addr  = r_bram_addr;
  assign bram_wdata = r_bram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port.sv
// ============================================================================
// Module      : tb_mem_port
// Description : Directed self-checking bench for mem_port with a behavioural
//               BRAM of read latency RD_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port;

  localparam int AW  = 15;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          done;
  logic [31:0]   rdata;
  logic          err;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata;

  int n_cmp;
  int n_mis;

  mem_port #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: two-stage read pipeline matching LAT = 2.
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd_p0;
  logic [31:0] rd_p1;
  assign bram_rdata = rd_p1;

  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end
      rd_p0 <= mem[bram_addr];
    end
    rd_p1 <= rd_p0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One access from an idle port; inputs are scrambled right after accept.
  task automatic access(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_en, input logic [3:0] exp_we,
                        input logic [31:0] exp_wd, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [AW-1:0] exp_addr;
    int n;
    exp_addr = a[AW+1:2];
    chk(tag, "ready_idle", {31'b0, ready}, 32'd1);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    tick;
    req = 1'b0; we = ~w; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h1234_5678;
    chk(tag, "ready_issue", {31'b0, ready}, 32'd0);
    chk(tag, "bram_en", {31'b0, bram_en}, {31'b0, exp_en});
    if (exp_en) begin
      chk(tag, "bram_we", {28'b0, bram_we}, {28'b0, exp_we});
      chk(tag, "bram_addr", {17'b0, bram_addr}, {17'b0, exp_addr});
      if (w) chk(tag, "bram_wdata", bram_wdata, exp_wd);
    end
    n = 1;
    while (!done && n < 20) begin
      tick;
      n++;
    end
    chk(tag, "latency", n, exp_lat);
    chk(tag, "ready_done", {31'b0, ready}, 32'd0);
    chk(tag, "rdata", rdata, exp_rd);
    chk(tag, "err", {31'b0, err}, {31'b0, exp_err});
    tick;
    chk(tag, "done_single", {31'b0, done}, 32'd0);
    chk(tag, "ready_after", {31'b0, ready}, 32'd1);
    chk(tag, "rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    int cnt;
    int first;
    int second;
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    rd_p0 = 32'h0;
    rd_p1 = 32'h0;
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    tick;
    tick;
    rst = 1'b0;

    chk("reset", "ready", {31'b0, ready}, 32'd1);
    chk("reset", "done", {31'b0, done}, 32'd0);
    chk("reset", "err", {31'b0, err}, 32'd0);
    chk("reset", "rdata", rdata, 32'h0);
    chk("reset", "bram_en", {31'b0, bram_en}, 32'd0);
    chk("reset", "bram_we", {28'b0, bram_we}, 32'd0);
    chk("reset", "bram_addr", {17'b0, bram_addr}, 32'd0);
    chk("reset", "bram_wdata", bram_wdata, 32'h0);

    access("sw_100",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 2, 32'h0,        1'b0);
    access("lw_100",  1'b0, 3'b010, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'hDEADBEEF, 1'b0);
    access("sw_clr",  1'b1, 3'b010, 32'h100, 32'h0,        1'b1, 4'b1111, 32'h0,        2, 32'hDEADBEEF, 1'b0);
    access("sb_103",  1'b1, 3'b000, 32'h103, 32'h12345680, 1'b1, 4'b1000, 32'h80808080, 2, 32'hDEADBEEF, 1'b0);
    access("lb_103",  1'b0, 3'b000, 32'h103, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'hFFFFFF80, 1'b0);
    access("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h00000080, 1'b0);
    access("sh_102",  1'b1, 3'b001, 32'h102, 32'hABCD8001, 1'b1, 4'b1100, 32'h80018001, 2, 32'h00000080, 1'b0);
    access("lh_102",  1'b0, 3'b001, 32'h102, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'hFFFF8001, 1'b0);
    access("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h00008001, 1'b0);
    access("lw_word", 1'b0, 3'b010, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h80010000, 1'b0);
    access("lb_102",  1'b0, 3'b000, 32'h102, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h00000001, 1'b0);
    access("lh_100",  1'b0, 3'b001, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h00000000, 1'b0);
    access("sb_101",  1'b1, 3'b000, 32'h101, 32'h0000007F, 1'b1, 4'b0010, 32'h7F7F7F7F, 2, 32'h00000000, 1'b0);
    access("lbu_101", 1'b0, 3'b100, 32'h101, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h0000007F, 1'b0);
    access("f3_011",  1'b0, 3'b011, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h80017F00, 1'b0);
    access("alias",   1'b0, 3'b010, 32'h00020100, 32'h0,   1'b1, 4'b0000, 32'h0,        4, 32'h80017F00, 1'b0);

    // req held across two loads; a brief drop while busy must not matter.
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h100; wdata = 32'h0;
    cnt = 0; first = 0; second = 0;
    for (int i = 1; i <= 14; i++) begin
      tick;
      if (done) begin
        cnt++;
        if (cnt == 1) first = i;
        if (cnt == 2) begin
          second = i;
          req = 1'b0;
        end
      end
      if (i == 2) req = 1'b0;
      if (i == 3) req = 1'b1;
    end
    chk("hold_req", "done_count", cnt, 32'd2);
    chk("hold_req", "first_done", first, 32'd4);
    chk("hold_req", "spacing", second - first, LAT + 3);
    chk("hold_req", "rdata", rdata, 32'h80017F00);

    // Reset during the WAIT cycle abandons the load.
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h100;
    tick;
    req = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_wait", "ready", {31'b0, ready}, 32'd1);
    chk("rst_wait", "done", {31'b0, done}, 32'd0);
    chk("rst_wait", "rdata", rdata, 32'h0);
    chk("rst_wait", "bram_addr", {17'b0, bram_addr}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done) cnt++;
    end
    chk("rst_wait", "no_done", cnt, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    access("lw_mis",  1'b0, 3'b010, 32'h102, 32'h0,        1'b0, 4'b0000, 32'h0,        2, 32'h0,        1'b1);
    access("sh_mis",  1'b1, 3'b001, 32'h101, 32'h00005555, 1'b0, 4'b0000, 32'h0,        2, 32'h0,        1'b1);
    access("lw_post", 1'b0, 3'b010, 32'h100, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h80017F00, 1'b0);
`else
    access("lw_mis",  1'b0, 3'b010, 32'h102, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'h80017F00, 1'b0);
    access("lh_odd",  1'b0, 3'b001, 32'h103, 32'h0,        1'b1, 4'b0000, 32'h0,        4, 32'hFFFF8001, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
